tone_detector: RTL
==================

# tone_detector

Recovers the sequencer note from an incoming square-wave tone, the inverse of the note-to-PWM path. It measures the period between rising edges of `tone_in` and classifies it against the eight note periods. After `MATCH_COUNT` consecutive matching periods it reports the 3-bit note code. It sits on the input/loopback side of the tone generator and feeds note-capture logic in the sequencer.

## Interface
- `TOL`, 256: allowed deviation of a measured full period from nominal, in clk cycles; must be < 677.
- `MATCH_COUNT`, 2: consecutive periods matching the same note required before the note is reported (≥1).
- `TIMEOUT`, 65536: cycles without a rising edge before silence is declared; must be > 46136 and < 2^17.
- `clk`  in  1  system clock (12 MHz nominal)
- `rst`  in  1  reset, asynchronous, active-high
- `tone_in`  in  1  asynchronous square wave
- `note`  out  3  detected note code, same encoding as the note decoder
- `note_valid`  out  1  high while a locked note is present
- `note_change`  out  1  one-cycle pulse when `note`/`note_valid` newly locks or changes
- `period`  out  17  last measured full period in cycles

## Operation
- Input chain: 2-flop synchronizer s1→s2, history flop s3; `rise = s2 & ~s3`.
- Period counter `cnt` (17 b): increments each cycle, saturates at `TIMEOUT`.
  - On `rise`: P := `cnt`, then `cnt` <= 1.
  - Rises exactly 2N cycles apart give P = 2N.
- Nominal full periods are 2× the half-period interval: C4 000 → 45880, D4 001 → 40868, E4 011 → 36408, F4 100 → 34380, G4 110 → 30612, A4 101 → 27272, B4 010 → 24296, C5 111 → 22942.
- Match rule: P matches note n iff `2N−TOL ≤ P ≤ 2N+TOL`.
  - Compare unsigned with no wrap.
  - Windows are disjoint by the `TOL` constraint, so at most one note matches.
- FSM states:
  - IDLE: no reference edge. On `rise`, go to MEASURE with `cnt`<=1 and no classification.
  - MEASURE: counting, not locked.
    - On `rise`, classify P and update the candidate: same note → run+1, saturating at `MATCH_COUNT`; different note → candidate=n, run=1; no match → run=0.
    - When run reaches `MATCH_COUNT`, go to LOCKED: `note`<=candidate, `note_valid`<=1, `note_change` pulses.
  - LOCKED: same classification as MEASURE.
    - A different note reaching `MATCH_COUNT`: `note` updates and `note_change` pulses. `note_valid` stays high throughout, and the old note holds until then.
    - A no-match P: `note_valid`<=0, `note` holds its value, return to MEASURE.
  - Timeout: in MEASURE or LOCKED, `cnt`==`TIMEOUT` with no `rise` → `note_valid`<=0, run=0, go to IDLE.
- `rise` has priority over timeout in the same cycle. P=`TIMEOUT` then classifies as no-match.
- `period` updates on every classified `rise`.

## Timing
- Reset values: `note`=000, `note_valid`=0, `note_change`=0, `period`=0, `cnt`=0, run=0, FSM=IDLE, sync flops=0.
- Reset is asynchronous: outputs clear immediately, mid-lock included. Re-lock needs 1+`MATCH_COUNT` rising edges.
- Latency: all outputs are registered. They update at the 3rd clk edge counting the one that first samples `tone_in` high on the completing edge: s1, then s2, then output register.
- `note_change` is high for exactly one cycle per lock or change. It never asserts on loss of lock.
- Locking from IDLE needs `MATCH_COUNT`+1 rising edges.

## Structure
- Shared package `note_pkg`:
  - note code localparams (NOTE_C4…NOTE_C5);
  - half-period interval constants;
  - function `note_half_interval(note)`.
- The note decoder and this block both import `note_pkg`.
- Sub-module `tone_sync_edge`: synchronizer plus rising-edge detect, outputs `rise`.
- The classifier is a combinational function in this module, looping over the 8 notes.

## Test plan
- Reset released, `tone_in`=0 → all outputs 0 and FSM IDLE for 70000 cycles, with no `note_change`.
- A4 wave (toggles every 13636) → `note`=101 and `note_valid`=1 three edges after the 3rd rising edge. One `note_change` pulse. `period`=27272.
- Locked A4, switch to C4 (22940 half-period) → `note_valid` stays 1 and `note`=101 for one period. `note`=000 on the 2nd matching C4 period, with one `note_change` pulse.
- Locked A4, then one period of 27528 (+256) → stays locked. Then one period of 27529 (+257) → `note_valid`=0, `note` holds 101.
- Locked, then `tone_in` held constant → `note_valid` falls when `cnt` reaches 65536 after the last rise, with no `note_change`. Resuming the wave re-locks after 3 rising edges.
- Assert `rst` for 1 cycle mid-lock → outputs 0 immediately. Re-lock to the same note after `MATCH_COUNT`+1 rising edges.

Source files
------------

// File: rtl/note_pkg.sv
// note_pkg: note codes and half-period intervals shared by the note decoder and tone detector.
package note_pkg;

    localparam logic [2:0] NOTE_C4 = 3'b000;
    localparam logic [2:0] NOTE_D4 = 3'b001;
    localparam logic [2:0] NOTE_E4 = 3'b011;
    localparam logic [2:0] NOTE_F4 = 3'b100;
    localparam logic [2:0] NOTE_G4 = 3'b110;
    localparam logic [2:0] NOTE_A4 = 3'b101;
    localparam logic [2:0] NOTE_B4 = 3'b010;
    localparam logic [2:0] NOTE_C5 = 3'b111;

    localparam logic [15:0] HALF_C4 = 16'd22940;
    localparam logic [15:0] HALF_D4 = 16'd20434;
    localparam logic [15:0] HALF_E4 = 16'd18204;
    localparam logic [15:0] HALF_F4 = 16'd17190;
    localparam logic [15:0] HALF_G4 = 16'd15306;
    localparam logic [15:0] HALF_A4 = 16'd13636;
    localparam logic [15:0] HALF_B4 = 16'd12148;
    localparam logic [15:0] HALF_C5 = 16'd11471;

    typedef struct packed {
        logic       hit;
        logic [2:0] code;
    } match_t;

    function automatic logic [15:0] note_half_interval(input logic [2:0] note);
        case (note)
            NOTE_C4: return HALF_C4;
            NOTE_D4: return HALF_D4;
            NOTE_E4: return HALF_E4;
            NOTE_F4: return HALF_F4;
            NOTE_G4: return HALF_G4;
            NOTE_A4: return HALF_A4;
            NOTE_B4: return HALF_B4;
            default: return HALF_C5;
        endcase
    endfunction

endpackage

// File: rtl/tone_sync_edge.sv
// tone_sync_edge: two-flop synchronizer plus history flop, flags a rising edge of tone_in.
module tone_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic tone_in,
    output logic rise
);

    logic s1, s2, s3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= tone_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/tone_detector.sv
// tone_detector: measures tone_in rise-to-rise period and locks onto the matching note code.
module tone_detector
    import note_pkg::*;
#(
    parameter int TOL         = 256,
    parameter int MATCH_COUNT = 2,
    parameter int TIMEOUT     = 65536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tone_in,
    output logic [2:0]  note,
    output logic        note_valid,
    output logic        note_change,
    output logic [16:0] period
);

    localparam int              RW      = $clog2(MATCH_COUNT + 1);
    localparam logic [RW-1:0]   RUN_MAX = RW'(MATCH_COUNT);
    localparam logic [16:0]     CNT_MAX = 17'(TIMEOUT);
    localparam logic [1:0]      IDLE    = 2'd0;
    localparam logic [1:0]      MEASURE = 2'd1;
    localparam logic [1:0]      LOCKED  = 2'd2;

    logic          rise;
    logic [1:0]    state;
    logic [16:0]   cnt;
    logic [RW-1:0] run, run_next;
    logic [2:0]    cand;
    match_t        m;

    // Widened to 18 bits so nominal+/-TOL never wraps.
    function automatic match_t classify(input logic [16:0] p);
        match_t      r;
        logic [17:0] nom;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            nom = {1'b0, note_half_interval(3'(i)), 1'b0};
            if ({1'b0, p} + 18'(TOL) >= nom && {1'b0, p} <= nom + 18'(TOL))
                r = '{hit: 1'b1, code: 3'(i)};
        end
        return r;
    endfunction

    tone_sync_edge u_sync (
        .clk(clk),
        .rst(rst),
        .tone_in(tone_in),
        .rise(rise)
    );

    always_comb begin
        m = classify(cnt);
        run_next = !m.hit ? '0 : m.code != cand ? RW'(1) : run == RUN_MAX ? run : run + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            run         <= '0;
            cand        <= '0;
            note        <= '0;
            note_valid  <= 1'b0;
            note_change <= 1'b0;
            period      <= '0;
        end else begin
            note_change <= 1'b0;
            cnt <= rise ? 17'd1 : cnt == CNT_MAX ? cnt : cnt + 1'b1;
            if (rise && state == IDLE) begin
                state <= MEASURE;
            end else if (rise) begin
                period <= cnt;
                run    <= run_next;
                if (m.hit)
                    cand <= m.code;
                if (!m.hit && state == LOCKED) begin
                    note_valid <= 1'b0;
                    state      <= MEASURE;
                end else if (run_next == RUN_MAX && (state == MEASURE || m.code != note)) begin
                    note        <= m.code;
                    note_valid  <= 1'b1;
                    note_change <= 1'b1;
                    state       <= LOCKED;
                end
            end else if (state != IDLE && cnt == CNT_MAX) begin
                note_valid <= 1'b0;
                run        <= '0;
                state      <= IDLE;
            end
        end
    end

endmodule
